scr1_tb_ialu_trace: RTL and testbench

Parametrised integer-ALU instruction tracer for the SCR1 testbench. It watches the EXU issue and retire strobes and pairs each tracked IALU command with its operands and writeback data. Completed records go into a FIFO, drained through a valid/ready port by a printer or scoreboard, and per-command hit counters are kept alongside. It supersedes single-opcode display loggers: it supports many commands, correct issue-to-retire pairing, back-pressure and overflow accounting.

---
 rtl/scr1_tb_ialu_trace.sv | 242 ++++++++++++++++++++++++
 tb/tb_scr1_tb_ialu_trace.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_tb_ialu_trace.sv
// ---------------------------------------------------------------------------
// scr1_tb_ialu_trace
//
// Integer-ALU instruction tracer. It watches the EXU issue and retire strobes
// and pairs each tracked IALU command with its operands and its writeback
// data. Finished records are queued in an in-order FIFO and drained through
// a valid/ready port. Per-command hit counters and a saturating overflow
// counter are kept alongside.
//
// Ports
//   clk, rst        core clock, asynchronous active-high reset
//   trace_en        global capture enable (a pending entry survives a clear)
//   cmd_mask        bit k = 1 tracks IALU command code k
//   reg_reg_only    1: track only REG_REG operand mode
//   iss_*           issue strobe and issued instruction fields
//   wb_vld          retire strobe, wb_rd_data is the value written to rd
//   kill            flush of the instruction currently in EXU
//   out_*           head record of the FIFO, valid/ready handshake
//   hit_cnt         flattened per-command counters, code k at [k*CNT_W +: CNT_W]
//   ovf_cnt         records lost because the FIFO was full (saturating)
//   ovf_flag        sticky, at least one record lost
//
// FSM states
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | nothing outstanding, waiting for a tracked issue
//   ST_PEND | one tracked instruction captured, waiting for retire/kill
// ---------------------------------------------------------------------------
module scr1_tb_ialu_trace #(
   parameter int XLEN    = 32,
   parameter int CMD_W   = 5,
   parameter int NUM_CMD = 16,
   parameter int DEPTH   = 8,
   parameter int CNT_W   = 32,
   parameter int SEQ_W   = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     trace_en,
   input  logic [NUM_CMD-1:0]       cmd_mask,
   input  logic                     reg_reg_only,
   input  logic                     iss_vld,
   input  logic [CMD_W-1:0]         iss_cmd,
   input  logic                     iss_reg_reg,
   input  logic                     iss_wb_ialu,
   input  logic [4:0]               iss_rd_addr,
   input  logic [XLEN-1:0]          iss_rs1_data,
   input  logic [XLEN-1:0]          iss_rs2_data,
   input  logic                     wb_vld,
   input  logic [XLEN-1:0]          wb_rd_data,
   input  logic                     kill,
   output logic                     out_vld,
   input  logic                     out_rdy,
   output logic [SEQ_W-1:0]         out_seq,
   output logic [CMD_W-1:0]         out_cmd,
   output logic [4:0]               out_rd_addr,
   output logic [XLEN-1:0]          out_rs1,
   output logic [XLEN-1:0]          out_rs2,
   output logic [XLEN-1:0]          out_rd,
   output logic [NUM_CMD*CNT_W-1:0] hit_cnt,
   output logic [CNT_W-1:0]         ovf_cnt,
   output logic                     ovf_flag
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      logic [SEQ_W-1:0] seq;
      logic [CMD_W-1:0] cmd;
      logic [4:0]       rd_addr;
      logic [XLEN-1:0]  rs1;
      logic [XLEN-1:0]  rs2;
      logic [XLEN-1:0]  rd;
   } rec_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PEND = 1'b1
   } state_t;

   state_t            state_q;
   logic [CMD_W-1:0]  pend_cmd_q;
   logic [4:0]        pend_rd_addr_q;
   logic [XLEN-1:0]   pend_rs1_q;
   logic [XLEN-1:0]   pend_rs2_q;

   logic [SEQ_W-1:0]  seq_q;
   logic [PTR_W:0]    wr_ptr_q;
   logic [PTR_W:0]    rd_ptr_q;
   rec_t              mem_q [DEPTH];
   logic [CNT_W-1:0]  hit_q [NUM_CMD];
   logic [CNT_W-1:0]  ovf_cnt_q;
   logic              ovf_flag_q;

   logic              mask_hit;
   logic              trk_iss;
   logic              capture;
   logic              rec_create;
   logic              fifo_empty;
   logic              fifo_full;
   logic              pop;
   logic              push;
   rec_t              new_rec;
   rec_t              head_rec;

   // Codes at or above NUM_CMD never match any loop index, so they are
   // rejected here without a separate range compare.
   always_comb begin
      mask_hit = 1'b0;
      for (int k = 0; k < NUM_CMD; k++) begin
         if (iss_cmd == CMD_W'(k)) begin
            mask_hit = cmd_mask[k];
         end
      end
   end

   assign trk_iss = iss_vld & trace_en & iss_wb_ialu & mask_hit
                  & (iss_reg_reg | ~reg_reg_only);

   // A new issue is only accepted when the slot is free or is being freed
   // this cycle; an issue while PEND is waiting is a protocol error.
   assign capture    = trk_iss & ((state_q == ST_IDLE) | wb_vld | kill);
   assign rec_create = (state_q == ST_PEND) & wb_vld;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         pend_cmd_q     <= '0;
         pend_rd_addr_q <= '0;
         pend_rs1_q     <= '0;
         pend_rs2_q     <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (trk_iss) begin
                  state_q <= ST_PEND;
               end
            end
            ST_PEND: begin
               if (wb_vld || kill) begin
                  state_q <= trk_iss ? ST_PEND : ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
         if (capture) begin
            pend_cmd_q     <= iss_cmd;
            pend_rd_addr_q <= iss_rd_addr;
            pend_rs1_q     <= iss_rs1_data;
            pend_rs2_q     <= iss_rs2_data;
         end
      end
   end

   assign new_rec = '{seq:     seq_q,
                      cmd:     pend_cmd_q,
                      rd_addr: pend_rd_addr_q,
                      rs1:     pend_rs1_q,
                      rs2:     pend_rs2_q,
                      rd:      wb_rd_data};

   // Sequence advances for every record, including ones lost to overflow,
   // so gaps in out_seq reveal exactly how many records were dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seq_q <= '0;
      end else if (rec_create) begin
         seq_q <= seq_q + SEQ_W'(1);
      end
   end

   // Extra MSB on each pointer distinguishes full from empty.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W])
                     & (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign pop        = ~fifo_empty & out_rdy;
   assign push       = rec_create & (~fifo_full | pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
         end
      end
   end

   // Storage needs no reset: every read is gated by the empty flag.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[PTR_W-1:0]] <= new_rec;
      end
   end

   assign head_rec    = mem_q[rd_ptr_q[PTR_W-1:0]];
   assign out_vld     = ~fifo_empty;
   assign out_seq     = fifo_empty ? '0 : head_rec.seq;
   assign out_cmd     = fifo_empty ? '0 : head_rec.cmd;
   assign out_rd_addr = fifo_empty ? '0 : head_rec.rd_addr;
   assign out_rs1     = fifo_empty ? '0 : head_rec.rs1;
   assign out_rs2     = fifo_empty ? '0 : head_rec.rs2;
   assign out_rd      = fifo_empty ? '0 : head_rec.rd;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_CMD; k++) begin
            hit_q[k] <= '0;
         end
      end else if (rec_create) begin
         for (int k = 0; k < NUM_CMD; k++) begin
            if ((pend_cmd_q == CMD_W'(k)) && (hit_q[k] != '1)) begin
               hit_q[k] <= hit_q[k] + CNT_W'(1);
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_CMD; g++) begin : g_hit
      assign hit_cnt[g*CNT_W +: CNT_W] = hit_q[g];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_cnt_q  <= '0;
         ovf_flag_q <= 1'b0;
      end else if (rec_create && !push) begin
         ovf_flag_q <= 1'b1;
         if (ovf_cnt_q != '1) begin
            ovf_cnt_q <= ovf_cnt_q + CNT_W'(1);
         end
      end
   end

   assign ovf_cnt  = ovf_cnt_q;
   assign ovf_flag = ovf_flag_q;

endmodule

// File: tb/tb_scr1_tb_ialu_trace.sv
module tb_scr1_tb_ialu_trace;

   localparam int XLEN    = 32;
   localparam int CMD_W   = 5;
   localparam int NUM_CMD = 16;
   localparam int DEPTH   = 8;
   localparam int CNT_W   = 32;
   localparam int SEQ_W   = 16;

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic                     trace_en = 1'b0;
   logic [NUM_CMD-1:0]       cmd_mask = '0;
   logic                     reg_reg_only = 1'b0;
   logic                     iss_vld = 1'b0;
   logic [CMD_W-1:0]         iss_cmd = '0;
   logic                     iss_reg_reg = 1'b0;
   logic                     iss_wb_ialu = 1'b0;
   logic [4:0]               iss_rd_addr = '0;
   logic [XLEN-1:0]          iss_rs1_data = '0;
   logic [XLEN-1:0]          iss_rs2_data = '0;
   logic                     wb_vld = 1'b0;
   logic [XLEN-1:0]          wb_rd_data = '0;
   logic                     kill = 1'b0;
   logic                     out_vld;
   logic                     out_rdy = 1'b0;
   logic [SEQ_W-1:0]         out_seq;
   logic [CMD_W-1:0]         out_cmd;
   logic [4:0]               out_rd_addr;
   logic [XLEN-1:0]          out_rs1;
   logic [XLEN-1:0]          out_rs2;
   logic [XLEN-1:0]          out_rd;
   logic [NUM_CMD*CNT_W-1:0] hit_cnt;
   logic [CNT_W-1:0]         ovf_cnt;
   logic                     ovf_flag;

   scr1_tb_ialu_trace #(
      .XLEN(XLEN), .CMD_W(CMD_W), .NUM_CMD(NUM_CMD),
      .DEPTH(DEPTH), .CNT_W(CNT_W), .SEQ_W(SEQ_W)
   ) dut (
      .clk(clk), .rst(rst), .trace_en(trace_en), .cmd_mask(cmd_mask),
      .reg_reg_only(reg_reg_only), .iss_vld(iss_vld), .iss_cmd(iss_cmd),
      .iss_reg_reg(iss_reg_reg), .iss_wb_ialu(iss_wb_ialu),
      .iss_rd_addr(iss_rd_addr), .iss_rs1_data(iss_rs1_data),
      .iss_rs2_data(iss_rs2_data), .wb_vld(wb_vld), .wb_rd_data(wb_rd_data),
      .kill(kill), .out_vld(out_vld), .out_rdy(out_rdy), .out_seq(out_seq),
      .out_cmd(out_cmd), .out_rd_addr(out_rd_addr), .out_rs1(out_rs1),
      .out_rs2(out_rs2), .out_rd(out_rd), .hit_cnt(hit_cnt),
      .ovf_cnt(ovf_cnt), .ovf_flag(ovf_flag)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [SEQ_W-1:0] seq;
      logic [CMD_W-1:0] cmd;
      logic [4:0]       rd_addr;
      logic [XLEN-1:0]  rs1;
      logic [XLEN-1:0]  rs2;
      logic [XLEN-1:0]  rd;
   } exp_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_rec    = 0;

   // Reference model: one outstanding tracked instruction, an unbounded
   // expectation queue and an occupancy count limited to DEPTH.
   exp_t        exp_q[$];
   bit          m_pend;
   exp_t        m_p;
   int unsigned m_seq;
   int unsigned m_occ;
   int unsigned m_ovf;
   bit          m_ovf_flag;
   int unsigned m_hit [NUM_CMD];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk or posedge rst) begin
      bit   trk;
      bit   pop_m;
      exp_t r;
      if (rst) begin
         exp_q.delete();
         m_pend = 0; m_seq = 0; m_occ = 0; m_ovf = 0; m_ovf_flag = 0;
         for (int k = 0; k < NUM_CMD; k++) m_hit[k] = 0;
      end else begin
         trk = iss_vld && trace_en && iss_wb_ialu && (iss_cmd < NUM_CMD)
               && cmd_mask[iss_cmd[3:0]] && (iss_reg_reg || !reg_reg_only);
         pop_m = (m_occ > 0) && out_rdy;
         if (m_pend && wb_vld) begin
            r     = m_p;
            r.seq = m_seq[SEQ_W-1:0];
            r.rd  = wb_rd_data;
            m_seq = (m_seq + 1) % (1 << SEQ_W);
            if (m_hit[r.cmd] != 32'hFFFF_FFFF) m_hit[r.cmd]++;
            if (m_occ < DEPTH || pop_m) begin
               exp_q.push_back(r);
               m_occ++;
            end else begin
               m_ovf_flag = 1;
               if (m_ovf != 32'hFFFF_FFFF) m_ovf++;
            end
         end
         if (pop_m) m_occ--;
         if (trk && (!m_pend || wb_vld || kill)) begin
            m_pend     = 1;
            m_p        = '0;
            m_p.cmd    = iss_cmd;
            m_p.rd_addr = iss_rd_addr;
            m_p.rs1    = iss_rs1_data;
            m_p.rs2    = iss_rs2_data;
         end else if (m_pend && (wb_vld || kill)) begin
            m_pend = 0;
         end
      end
   end

   // Monitor: compares the head record whenever one is presented.
   always @(negedge clk) begin
      logic [NUM_CMD*CNT_W-1:0] eh;
      exp_t got;
      for (int k = 0; k < NUM_CMD; k++) eh[k*CNT_W +: CNT_W] = m_hit[k];
      chk("out_vld", 64'(out_vld), 64'(m_occ > 0));
      chk("ovf_cnt", 64'(ovf_cnt), 64'(m_ovf));
      chk("ovf_flag", 64'(ovf_flag), 64'(m_ovf_flag));
      n_checks++;
      if (hit_cnt !== eh) begin
         n_fail++;
         $display("FAIL hit_cnt: got %h expected %h", hit_cnt, eh);
      end
      if (out_vld) begin
         got = '{seq: out_seq, cmd: out_cmd, rd_addr: out_rd_addr,
                 rs1: out_rs1, rs2: out_rs2, rd: out_rd};
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL record: got %h expected none", got);
         end else begin
            if (got !== exp_q[0]) begin
               n_fail++;
               $display("FAIL record: got %h expected %h", got, exp_q[0]);
            end
            if (out_rdy) begin
               void'(exp_q.pop_front());
               n_rec++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input bit iv, input logic [4:0] cmd, input logic [4:0] rd,
                      input logic [31:0] a, input logic [31:0] b,
                      input bit wv, input logic [31:0] wd, input bit k);
      iss_vld      = iv;
      iss_cmd      = cmd;
      iss_reg_reg  = 1'b1;
      iss_wb_ialu  = 1'b1;
      iss_rd_addr  = rd;
      iss_rs1_data = a;
      iss_rs2_data = b;
      wb_vld       = wv;
      wb_rd_data   = wd;
      kill         = k;
      tick();
      iss_vld = 1'b0; wb_vld = 1'b0; kill = 1'b0;
   endtask

   function automatic logic [4:0] tracked_cmd();
      logic [4:0] c;
      c = 5'($urandom_range(0, 15));
      if (c == 5'd2) c = 5'd1;
      return c;
   endfunction

   // n_rec records: issue, (n_rec-1) x retire+issue, then retire or retire+issue.
   task automatic chain(input int n, input bit leave_pend);
      cyc(1, tracked_cmd(), 5'($urandom), $urandom, $urandom, 0, 0, 0);
      for (int i = 0; i < n - 1; i++)
         cyc(1, tracked_cmd(), 5'($urandom), $urandom, $urandom, 1, $urandom, 0);
      if (leave_pend)
         cyc(1, tracked_cmd(), 5'($urandom), $urandom, $urandom, 1, $urandom, 0);
      else
         cyc(0, 0, 0, 0, 0, 1, $urandom, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int rec_before;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_vld", 64'(out_vld), 64'd0);
      chk("rst_out_rd", 64'(out_rd), 64'd0);
      chk("rst_ovf_cnt", 64'(ovf_cnt), 64'd0);
      rst = 1'b0;
      trace_en = 1'b1;
      cmd_mask = 16'hFFFB;
      out_rdy  = 1'b1;

      // Single ADD, retired two cycles after issue.
      cyc(1, 5'd1, 5'd3, 32'd5, 32'd7, 0, 0, 0);
      idle(1);
      cyc(0, 0, 0, 0, 0, 1, 32'd12, 0);
      chk("add_vld", 64'(out_vld), 64'd1);
      chk("add_rec", 64'({out_seq, out_cmd, out_rd_addr}), 64'({16'd0, 5'd1, 5'd3}));
      chk("add_ops", {out_rs1, out_rs2}, {32'd5, 32'd7});
      chk("add_rd", 64'(out_rd), 64'd12);
      chk("add_hit", 64'(hit_cnt[1*CNT_W +: CNT_W]), 64'd1);
      idle(1);
      chk("add_one_cycle", 64'(out_vld), 64'd0);

      // Back-to-back retire + issue.
      chain(4, 0);
      idle(3);

      // Masked command and killed instruction produce nothing.
      rec_before = n_rec;
      cyc(1, 5'd2, 5'd4, 32'd1, 32'd2, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 32'd3, 0);
      cyc(1, 5'd1, 5'd4, 32'd1, 32'd2, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1, 32'd9, 0);
      idle(2);
      chk("mask_kill_norec", 64'(n_rec), 64'(rec_before));
      chk("mask_hit2", 64'(hit_cnt[2*CNT_W +: CNT_W]), 64'd0);

      // Overflow with 10 records into an 8-deep FIFO.
      rst = 1'b1; tick(); rst = 1'b0;
      out_rdy = 1'b0;
      chain(10, 0);
      chk("ovf_vld", 64'(out_vld), 64'd1);
      chk("ovf_cnt2", 64'(ovf_cnt), 64'd2);
      chk("ovf_flag1", 64'(ovf_flag), 64'd1);
      chk("ovf_head_seq", 64'(out_seq), 64'd0);
      out_rdy = 1'b1;
      idle(8);
      chk("drained", 64'(out_vld), 64'd0);
      chain(1, 0);
      chk("seq_after_ovf", 64'(out_seq), 64'd10);
      idle(1);

      // Full FIFO with a simultaneous pop and push.
      out_rdy = 1'b0;
      chain(8, 1);
      chk("full_head", 64'(out_seq), 64'd11);
      out_rdy = 1'b1;
      cyc(0, 0, 0, 0, 0, 1, $urandom, 0);
      chk("full_pp_ovf", 64'(ovf_cnt), 64'd2);
      chk("full_pp_head", 64'(out_seq), 64'd12);
      idle(10);

      // Asynchronous reset with buffered and pending records.
      rst = 1'b1; tick(); rst = 1'b0;
      out_rdy = 1'b0;
      chain(3, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_vld", 64'(out_vld), 64'd0);
      chk("arst_ovf", 64'(ovf_cnt), 64'd0);
      chk("arst_hit", 64'(hit_cnt != '0), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      out_rdy = 1'b1;
      tick();
      chain(1, 0);
      chk("arst_recover_seq", 64'(out_seq), 64'd0);
      chk("arst_recover_vld", 64'(out_vld), 64'd1);
      idle(2);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) begin
            cmd_mask     = 16'($urandom);
            reg_reg_only = ($urandom_range(0, 3) == 0);
         end
         trace_en     = ($urandom_range(0, 9) != 0);
         out_rdy      = ($urandom_range(0, 9) < 7);
         iss_vld      = $urandom_range(0, 1);
         iss_cmd      = 5'($urandom_range(0, 20));
         iss_reg_reg  = $urandom_range(0, 1);
         iss_wb_ialu  = ($urandom_range(0, 4) != 0);
         iss_rd_addr  = 5'($urandom);
         iss_rs1_data = $urandom;
         iss_rs2_data = $urandom;
         wb_vld       = ($urandom_range(0, 9) < 4);
         wb_rd_data   = $urandom;
         kill         = ($urandom_range(0, 9) == 0);
         tick();
      end
      iss_vld = 1'b0; wb_vld = 1'b0; kill = 1'b0;
      out_rdy = 1'b1;
      idle(12);
      chk("final_empty", 64'(out_vld), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
